// File: rtl/fifo_tx_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_tx_reader
// Purpose  : Pops one word from the async FIFO and hands it to the UART
//            transmitter. It then waits for the frame to finish and may insert an
//            inter-frame gap.
// Revision : 1.0
// ============================================================================
module fifo_tx_reader #(
    parameter int WIDTH       = 8,
    parameter int RD_LATENCY  = 1,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 empty,
    input  logic [WIDTH-1:0]     rd_data,
    output logic                 r_inc,
    input  logic                 tx_busy,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 tx_valid,
    output logic                 active,
    output logic                 drop_err,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP       = 3'd1,
        S_LATCH     = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    // Terminal values for the shared cycle counter in each timed state.
    localparam logic [7:0] c_LAT_LAST = 8'(RD_LATENCY - 1);
    localparam logic [7:0] c_ACK_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] c_GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam bit         c_HAS_GAP  = (GAP_CYCLES > 0);

    state_t     r_state;
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_inc     <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            active    <= 1'b0;
            drop_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            r_inc    <= 1'b0;
            drop_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && !empty && !tx_busy) begin
                        r_state <= S_POP;
                        r_inc   <= 1'b1;
                        active  <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_LATCH;
                    r_cnt   <= 8'd0;
                end
                S_LATCH: begin
                    if (r_cnt == c_LAT_LAST) begin
                        tx_data  <= rd_data;
                        tx_valid <= 1'b1;
                        r_cnt    <= 8'd0;
                        r_state  <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SEND: begin
                    if (tx_busy) begin
                        tx_valid <= 1'b0;
                        r_state  <= S_WAIT_DONE;
                    end else if (r_cnt == c_ACK_LAST) begin
                        // Transmitter never acknowledged: discard the word.
                        tx_valid <= 1'b0;
                        drop_err <= 1'b1;
                        active   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
                        r_cnt     <= 8'd0;
                        if (c_HAS_GAP) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            active  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                        active  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    tx_valid <= 1'b0;
                    active   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_tx_reader.md
Name: fifo_tx_reader

Overview:
Read-side consumer of the async FIFO in the UART clock domain.
- Pops one word at a time when the FIFO is not empty, holds it stable and presents it to the UART transmitter with a valid/busy handshake.
- Waits for the frame to finish, optionally inserts an inter-frame gap, then repeats.
- Replaces ad-hoc pulse-gen pop logic with a single FSM. Provides a transmitted-frame counter and a timeout drop indication.

Parameters:
WIDTH, 8, data word width (matches FIFO WIDTH)
RD_LATENCY, 1, cycles from the R_INC pulse to RD_DATA valid (1..4)
GAP_CYCLES, 0, idle cycles inserted after each completed frame (0..255)
ACK_TIMEOUT, 255, max SEND cycles waiting for TX_BUSY rise before the word is dropped (1..255)
CNT_WIDTH, 16, width of FRAME_CNT

Ports:
CLK  in  1  block clock (UART/read clock)
RST  in  1  synchronous active-high reset
ENABLE  in  1  allow new pops; sampled only in IDLE
EMPTY  in  1  FIFO empty flag
RD_DATA  in  WIDTH  FIFO read data
R_INC  out  1  FIFO pop request, exactly one-cycle pulse per word
TX_BUSY  in  1  UART TX busy; high for the whole frame
TX_DATA  out  WIDTH  word to transmit; stable while TX_VALID=1
TX_VALID  out  1  word available to UART TX
ACTIVE  out  1  high in any state except IDLE
DROP_ERR  out  1  one-cycle pulse when a word is discarded on timeout
FRAME_CNT  out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (RST=1 at the edge): state=IDLE. R_INC=0, TX_VALID=0, TX_DATA=0, ACTIVE=0, DROP_ERR=0, FRAME_CNT=0, internal counters=0.
  - Reset mid-operation aborts immediately; an in-flight word is lost.
  - FRAME_CNT is not incremented for the aborted word.
- All outputs are registered.
- IDLE -> POP when ENABLE=1, EMPTY=0 and TX_BUSY=0 are sampled together. Otherwise stay in IDLE.
  - TX_BUSY=1 in IDLE (busy from another source) blocks the pop.
- POP: R_INC=1 for this single cycle, then LATCH. R_INC is never high in any other state.
- LATCH: counts RD_LATENCY cycles. TX_DATA<=RD_DATA at the edge ending the last LATCH cycle, then SEND.
  - With RD_LATENCY=1: R_INC high in cycle c, RD_DATA sampled at end of c+1, TX_VALID high from c+2.
- SEND: TX_VALID=1, TX_DATA held.
  - On TX_BUSY=1 sampled -> WAIT_DONE; TX_VALID low from the next cycle.
  - If ACK_TIMEOUT cycles elapse in SEND without TX_BUSY=1: TX_VALID drops, DROP_ERR pulses one cycle, state -> IDLE.
  - FRAME_CNT is unchanged on a timeout drop.
- WAIT_DONE: on TX_BUSY=0 sampled:
  - FRAME_CNT+1, wrapping from all-ones to 0.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: stays exactly GAP_CYCLES cycles, then IDLE.
- ENABLE deassertion outside IDLE has no effect. The current word completes; no new pop follows.
- EMPTY only matters in IDLE. Never pop when EMPTY=1, so there is no underflow.
- Back-to-back throughput with GAP_CYCLES=0: the next POP comes 1 cycle after the WAIT_DONE exit (IDLE evaluation cycle).
- Only one word is outstanding at a time. TX_DATA changes only at the LATCH capture edge or reset.

Test Plan:
1. Reset with RD_LATENCY=1 → all outputs 0; FIFO holds 0xA5, EMPTY=0, ENABLE=1, TX_BUSY=0.
   - Required: R_INC one cycle at c; TX_DATA=0xA5 and TX_VALID=1 at c+2.
   - TX model raises BUSY 1 cycle later for 10 cycles → TX_VALID low next cycle, FRAME_CNT=1 after BUSY falls.
2. FIFO holds 3 words 0x01, 0x02, 0x03, GAP_CYCLES=0 → exactly 3 R_INC pulses, words sent in order, FRAME_CNT=3.
   - EMPTY=1 afterwards → no 4th R_INC; ACTIVE returns to 0.
3. GAP_CYCLES=4 → cycles from BUSY-fall sampling to the next R_INC equal 4 (GAP) + 1 (IDLE); exactly 4 GAP cycles.
4. ACK_TIMEOUT=8 with TX_BUSY held 0 → TX_VALID high exactly 8 cycles, DROP_ERR one-cycle pulse, FRAME_CNT unchanged, state back to IDLE.
5. RST asserted 1 cycle into SEND with word 0x3C → next cycle TX_VALID=0, TX_DATA=0, FRAME_CNT=0.
   - After release, the next FIFO word is popped normally.
6. CNT_WIDTH=2, send 5 frames → FRAME_CNT sequence 1, 2, 3, 0, 1.
   - ENABLE dropped during WAIT_DONE of frame 5 → frame completes, no further R_INC.
